// File: rtl/freq_frame_buffer.sv
// Ping-pong frame store for complex FFT frames: the Avalon-ST sink fills one bank while the source drains the other.
// Optional: define FREQ_FRAME_BUFFER_BITREV_EN to read full-length frames in bit-reversed address order.
module freq_frame_buffer #(
    parameter int DATA_WIDTH = 20,
    parameter int FRAME_SIZE = 2048,
    parameter int IDX_W      = $clog2(FRAME_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sink_valid,
    input  logic                  sink_sop,
    input  logic                  sink_eop,
    input  logic [DATA_WIDTH-1:0] sink_re,
    input  logic [DATA_WIDTH-1:0] sink_im,
    output logic                  sink_ready,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic                  source_sop,
    output logic                  source_eop,
    output logic [DATA_WIDTH-1:0] source_re,
    output logic [DATA_WIDTH-1:0] source_im,
    output logic [IDX_W-1:0]      source_idx,
    output logic                  frame_err
);

    localparam int LEN_W = IDX_W + 1;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(FRAME_SIZE);
    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(FRAME_SIZE - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_OUT} rstate_t;

    // Asynchronous assert, synchronous release
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    logic [2*DATA_WIDTH-1:0] mem [2*FRAME_SIZE];
    logic [2*DATA_WIDTH-1:0] ram_q;

    logic [1:0]       bank_full, full_next;
    logic [1:0]       fetch_started, started_next;
    logic [LEN_W-1:0] bank_len [2];
    logic             wr_bank, rd_bank;

    wstate_t          w_state, w_next;
    logic [IDX_W-1:0] wr_pos, pos_next, mem_wpos;
    logic             accept, mem_we, commit, err_next, drain;
    logic [LEN_W-1:0] commit_len;

    rstate_t          r_state, r_next;
    logic             fb, fb_next;
    logic [IDX_W-1:0] fpos, fpos_next, cur_pos, rd_idx;
    logic [LEN_W-1:0] flen, flen_next, cur_len;
    logic             start, can_read, rd_en, cur_last, out_load;
    logic             q_valid, q_sop, q_eop;
    logic [IDX_W-1:0] q_idx;

    assign accept = sink_valid && sink_ready;

    always_comb begin
        w_next     = w_state;
        pos_next   = wr_pos;
        mem_we     = 1'b0;
        mem_wpos   = wr_pos;
        commit     = 1'b0;
        commit_len = '0;
        err_next   = 1'b0;
        if (accept) begin
            if (sink_sop) begin
                mem_we   = 1'b1;
                mem_wpos = '0;
                if (sink_eop) begin
                    commit     = 1'b1;
                    commit_len = LEN_W'(1);
                    w_next     = W_IDLE;
                end else begin
                    pos_next = IDX_W'(1);
                    w_next   = W_FILL;
                end
            end else begin
                case (w_state)
                    W_IDLE: err_next = 1'b1;
                    W_FILL: begin
                        mem_we = 1'b1;
                        if (sink_eop) begin
                            commit     = 1'b1;
                            commit_len = LEN_W'(wr_pos) + LEN_W'(1);
                            w_next     = W_IDLE;
                        end else if (wr_pos == LAST_POS) begin
                            commit     = 1'b1;
                            commit_len = FULL_LEN;
                            err_next   = 1'b1;
                            w_next     = W_DROP;
                        end else begin
                            pos_next = wr_pos + IDX_W'(1);
                        end
                    end
                    W_DROP: if (sink_eop) w_next = W_IDLE;
                    default: w_next = W_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[{wr_bank, mem_wpos}] <= {sink_re, sink_im};
    end

    always_ff @(posedge clk) begin
        if (rd_en) ram_q <= mem[{fb, rd_idx}];
    end

    // Fetch side runs ahead of the output register and may start the next bank
    // while the current one is still draining; drain side tracks rd_bank.
    assign out_load = q_valid && (!source_valid || source_ready);
    assign can_read = !q_valid || out_load;
    assign start    = (r_state == R_IDLE) && bank_full[fb] && !fetch_started[fb];
    assign cur_pos  = (r_state == R_OUT) ? fpos : '0;
    assign cur_len  = (r_state == R_OUT) ? flen : bank_len[fb];
    assign rd_en    = can_read && ((r_state == R_OUT) || start);
    assign cur_last = (LEN_W'(cur_pos) + LEN_W'(1)) == cur_len;
    assign drain    = source_valid && source_ready && source_eop;

`ifdef FREQ_FRAME_BUFFER_BITREV_EN
    function automatic logic [IDX_W-1:0] bit_reverse(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < IDX_W; i++) r[i] = v[IDX_W-1-i];
        return r;
    endfunction
    assign rd_idx = (cur_len == FULL_LEN) ? bit_reverse(cur_pos) : cur_pos;
`else
    assign rd_idx = cur_pos;
`endif

    always_comb begin
        r_next    = r_state;
        fpos_next = fpos;
        flen_next = flen;
        fb_next   = fb;
        if (rd_en) begin
            if (cur_last) begin
                fb_next = ~fb;
                r_next  = R_IDLE;
            end else begin
                r_next    = R_OUT;
                fpos_next = cur_pos + IDX_W'(1);
                flen_next = cur_len;
            end
        end
    end

    always_comb begin
        full_next    = bank_full;
        started_next = fetch_started;
        if (commit) full_next[wr_bank] = 1'b1;
        if (start && can_read) started_next[fb] = 1'b1;
        if (drain) begin
            full_next[rd_bank]    = 1'b0;
            started_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state       <= W_IDLE;
            wr_pos        <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            frame_err     <= 1'b0;
            sink_ready    <= 1'b1;
            bank_full     <= '0;
            fetch_started <= '0;
            bank_len[0]   <= '0;
            bank_len[1]   <= '0;
        end else begin
            w_state       <= w_next;
            wr_pos        <= pos_next;
            frame_err     <= err_next;
            bank_full     <= full_next;
            fetch_started <= started_next;
            sink_ready    <= !(full_next[0] && full_next[1]);
            if (commit) begin
                bank_len[wr_bank] <= commit_len;
                wr_bank           <= ~wr_bank;
            end
            if (drain) rd_bank <= ~rd_bank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= R_IDLE;
            fb           <= 1'b0;
            fpos         <= '0;
            flen         <= '0;
            q_valid      <= 1'b0;
            q_sop        <= 1'b0;
            q_eop        <= 1'b0;
            q_idx        <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_re    <= '0;
            source_im    <= '0;
            source_idx   <= '0;
        end else begin
            r_state <= r_next;
            fb      <= fb_next;
            fpos    <= fpos_next;
            flen    <= flen_next;
            if (rd_en) begin
                q_valid <= 1'b1;
                q_sop   <= (cur_pos == '0);
                q_eop   <= cur_last;
                q_idx   <= rd_idx;
            end else if (out_load) begin
                q_valid <= 1'b0;
            end
            if (out_load) begin
                source_valid <= 1'b1;
                source_sop   <= q_sop;
                source_eop   <= q_eop;
                source_idx   <= q_idx;
                source_re    <= ram_q[2*DATA_WIDTH-1:DATA_WIDTH];
                source_im    <= ram_q[DATA_WIDTH-1:0];
            end else if (source_ready) begin
                source_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_frame_buffer.sv
// Directed bench for freq_frame_buffer with FRAME_SIZE=8; expectations follow FREQ_FRAME_BUFFER_BITREV_EN when defined.
module tb_freq_frame_buffer;

    localparam int DW = 20;
    localparam int FS = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sink_valid, sink_sop, sink_eop, sink_ready;
    logic [DW-1:0] sink_re, sink_im;
    logic          source_valid, source_ready, source_sop, source_eop, frame_err;
    logic [DW-1:0] source_re, source_im;
    logic [IW-1:0] source_idx;

    always #5 clk = ~clk;

    freq_frame_buffer #(.DATA_WIDTH(DW), .FRAME_SIZE(FS)) dut (
        .clk(clk), .reset_n(reset_n),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_re(sink_re), .sink_im(sink_im), .sink_ready(sink_ready),
        .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_re(source_re), .source_im(source_im), .source_idx(source_idx),
        .frame_err(frame_err)
    );

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [IW-1:0] idx;
        logic          sop;
        logic          eop;
        int            cyc;
    } beat_t;

    beat_t beats[$];
    int    cyc = 0;
    int    err_cnt = 0;
    int    checks = 0;
    int    failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (source_valid && source_ready)
            beats.push_back('{source_re, source_im, source_idx, source_sop, source_eop, cyc});
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_addr(input int i, input int len);
`ifdef FREQ_FRAME_BUFFER_BITREV_EN
        if (len == FS) return {i[0], i[1], i[2]};
`endif
        return (len > 0) ? i : 0;
    endfunction

    task automatic send_beat(input logic sop, input logic eop, input int v);
        int n;
        n = 0;
        sink_valid = 1'b1;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_re    = DW'(v);
        sink_im    = DW'(-v);
        while (!sink_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!sink_ready) check("sink_ready_timeout", 64'(sink_ready), 64'd1);
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    task automatic send_frame(input int base, input int len, input logic with_eop);
        for (int k = 0; k < len; k++)
            send_beat(k == 0, with_eop && (k == len - 1), base + k);
    endtask

    task automatic expect_frame(input string tag, input int base, input int len,
                                output int first_cyc, output int last_cyc);
        int n;
        n = 0;
        first_cyc = 0;
        last_cyc = 0;
        while (beats.size() < len && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (beats.size() < len) begin
            check({tag, "_timeout"}, 64'(beats.size()), 64'(len));
            return;
        end
        for (int i = 0; i < len; i++) begin
            beat_t         b;
            int            a;
            int            v;
            logic [DW-1:0] e_im;
            b = beats.pop_front();
            a = exp_addr(i, len);
            v = base + a;
            e_im = DW'(-v);
            check($sformatf("%s_re%0d", tag, i), 64'(b.re), 64'(v));
            check($sformatf("%s_im%0d", tag, i), 64'(b.im), 64'(e_im));
            check($sformatf("%s_idx%0d", tag, i), 64'(b.idx), 64'(a));
            check($sformatf("%s_sop%0d", tag, i), 64'(b.sop), 64'(i == 0));
            check($sformatf("%s_eop%0d", tag, i), 64'(b.eop), 64'(i == len - 1));
            if (i == 0) first_cyc = b.cyc;
            last_cyc = b.cyc;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sink_ready"}, 64'(sink_ready), 64'd1);
        check({tag, "_valid"}, 64'(source_valid), 64'd0);
        check({tag, "_sop"}, 64'(source_sop), 64'd0);
        check({tag, "_eop"}, 64'(source_eop), 64'd0);
        check({tag, "_re"}, 64'(source_re), 64'd0);
        check({tag, "_im"}, 64'(source_im), 64'd0);
        check({tag, "_idx"}, 64'(source_idx), 64'd0);
        check({tag, "_err"}, 64'(frame_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int f0, l0, f1, l1, eop_cyc, err0, n;
        reset_n = 1'b0;
        sink_valid = 1'b0;
        sink_sop = 1'b0;
        sink_eop = 1'b0;
        sink_re = '0;
        sink_im = '0;
        source_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("rst_hold");
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_outputs_zero("rst_release");

        // 8-beat frame and first-valid latency
        send_frame(0, 8, 1'b1);
        eop_cyc = cyc;
        expect_frame("t1", 0, 8, f0, l0);
        check("t1_latency", 64'(f0 - eop_cyc), 64'd2);
        check("t1_idle_after", 64'(source_valid), 64'd0);

        // Two frames stalled, then released as 16 contiguous beats
        source_ready = 1'b0;
        send_frame(16, 8, 1'b1);
        check("t2_ready_one_full", 64'(sink_ready), 64'd1);
        send_frame(32, 8, 1'b1);
        check("t2_ready_both_full", 64'(sink_ready), 64'd0);
        check("t2_hold_valid", 64'(source_valid), 64'd1);
        check("t2_hold_re", 64'(source_re), 64'd16);
        repeat (3) @(posedge clk);
        #1;
        check("t2_hold_re_later", 64'(source_re), 64'd16);
        check("t2_hold_sop", 64'(source_sop), 64'd1);
        source_ready = 1'b1;
        expect_frame("t2a", 16, 8, f0, l0);
        expect_frame("t2b", 32, 8, f1, l1);
        check("t2_contiguous", 64'(l1 - f0), 64'd15);
        check("t2_ready_back", 64'(sink_ready), 64'd1);

        // Overflow: 11 beats without eop
        err0 = err_cnt;
        send_frame(48, 11, 1'b0);
        expect_frame("t4", 48, 8, f0, l0);
        repeat (10) @(posedge clk);
        #1;
        check("t4_err_pulses", 64'(err_cnt - err0), 64'd1);
        check("t4_dropped", 64'(beats.size()), 64'd0);

        // 3-beat frame then a single sop+eop beat (first sop arrives in W_DROP)
        err0 = err_cnt;
        send_frame(64, 3, 1'b1);
        send_beat(1'b1, 1'b1, 80);
        expect_frame("t3a", 64, 3, f0, l0);
        expect_frame("t3b", 80, 1, f0, l0);
        check("t3_no_err", 64'(err_cnt - err0), 64'd0);

        // Stray beat without sop
        err0 = err_cnt;
        send_beat(1'b0, 1'b0, 5);
        repeat (10) @(posedge clk);
        #1;
        check("t5_stray_err", 64'(err_cnt - err0), 64'd1);
        check("t5_stray_none", 64'(beats.size()), 64'd0);

        // Reset mid-frame
        send_beat(1'b1, 1'b0, 90);
        send_beat(1'b0, 1'b0, 91);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("t5_rst_frame");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_residual_a", 64'(beats.size()), 64'd0);
        check("t5_valid_a", 64'(source_valid), 64'd0);

        // Reset mid-drain
        source_ready = 1'b0;
        send_frame(96, 4, 1'b1);
        n = 0;
        while (!source_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_drain_valid", 64'(source_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("t5_rst_drain");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        source_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_residual_b", 64'(beats.size()), 64'd0);

        // Clean frame after reset
        send_frame(112, 2, 1'b1);
        expect_frame("t6", 112, 2, f0, l0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
